ssd_scan: RTL
=============

# ssd_scan

Multiplexed multi-digit seven-segment display driver. It extends single-digit BCD decoding to a parametrised bank of NUM_DIGITS hexadecimal digits (0–F) driven through one shared segment bus. A prescaler-timed digit scan drives the anodes one at a time. A load handshake double-buffers the value so that displayed digits never tear mid-frame. It sits between the datapath (for example, multiplier result registers) and the board display pins.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1–8.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal minimum 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- load  in  1  single-cycle strobe; captures value and dp_in.
- value  in  4*NUM_DIGITS  nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- seg  out  7  segments {A,B,C,D,E,F,G}, MSB = A, active-high, registered.
- dp  out  1  decimal point of the enabled digit, active-high, registered.
- an  out  NUM_DIGITS  one-hot digit enable, active-high, registered; an[k] enables digit k.
- upd_done  out  1  one-cycle pulse when a loaded value becomes visible.

## Operation
- State:
  - prescale counter cnt, 0..REFRESH_DIV-1.
  - digit index idx, 0..NUM_DIGITS-1.
  - pending register and pending flag.
  - display register.
- Scan:
  - cnt increments every cycle.
  - When cnt = REFRESH_DIV-1: cnt wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
  - When NUM_DIGITS = 1, idx stays 0 and the wrap event fires every REFRESH_DIV cycles.
- Load: when load = 1, pending takes value and dp_in, and the pending flag is set. A second load before commit overwrites pending; only the last value is ever shown.
- Commit (frame boundary):
  - Occurs on the edge where idx wraps to 0.
  - If the pending flag is set: display takes pending (its pre-edge contents), the flag clears, and upd_done is high the next cycle for exactly one cycle.
  - If the flag is clear, nothing happens and no pulse is emitted.
- Simultaneous load and commit: the commit uses the old pending contents. The new value lands in pending and the flag stays set, so it commits at the next frame boundary.
- Decode, per nibble:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Output registers, each cycle:
  - an takes one-hot(idx).
  - seg takes decode(display nibble idx).
  - dp takes display dp bit idx.
- Reset values: seg=0, dp=0, an=0, upd_done=0, cnt=0, idx=0, pending flag=0, pending=0, display=0.
- Reset mid-operation discards pending (the flag clears) and suppresses any upd_done pulse.

## Timing
- Output latency is 1 cycle from idx/display to an/seg/dp.
- The first cycle after rst_n rises: an=0. From the second cycle: an=one-hot(0), seg=1111110.
- Each digit is enabled for exactly REFRESH_DIV cycles. The frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-visible latency is at most one frame plus 1 cycle. upd_done coincides with the first cycle that an=one-hot(0) shows the new value.
- The load strobe is sampled every cycle. There is no backpressure; load is always accepted.

## Configuration
- SSD_LZB_EN, when defined (leading-zero blanking):
  - Digit k (k ≥ 1) drives seg=0000000 when it and all higher digits in display are zero.
  - Digit 0 is never blanked.
  - an keeps scanning blanked digits; dp is unaffected by blanking.
- SSD_LZB_EN undefined: every digit is decoded, including leading zeros.

## Structure
- Shared package ssd_pkg holds:
  - localparam segment codes SEG_0..SEG_F and SEG_BLANK (0000000).
  - The segment bit-order constants (SEG_A index 6 … SEG_G index 0).
- Sub-module ssd_hex_decode: combinational 4-bit nibble to 7-bit segment code, built from the ssd_pkg constants.
- Top-level ssd_scan holds the prescaler, scan index, double buffer, blanking logic and output registers.

## Test plan
Bench configuration: NUM_DIGITS=4, REFRESH_DIV=4 (frame = 16 cycles).
1. Reset: rst_n low for 3 cycles, with load=1 driven -> seg=0, dp=0, an=0000, upd_done=0 throughout; no commit afterwards without a new load.
2. Load value=16'h1234, dp_in=4'b0100 -> upd_done pulses once at the next frame start. Per 4-cycle slot: an=0001 seg=0110011; an=0010 seg=1111001; an=0100 seg=1101101 dp=1; an=1000 seg=0110000.
3. Hex digits: load 16'hABCF -> digit0 seg=1000111, digit1 seg=1001110, digit2 seg=0011111, digit3 seg=1110111.
4. Loads of 16'h1111 then 16'h2222 in one frame, plus a load of 16'h3333 on the wrap edge -> the next frame shows 2222 and the following frame shows 3333; upd_done pulses exactly twice.
5. SSD_LZB_EN defined, value=16'h0050 -> digits 3 and 2 give seg=0000000 while an still asserts; digit1 seg=1011011, digit0 seg=1111110. value=0 -> only digit0 is lit (1111110). Without the macro, digit3 of 16'h0050 gives seg=1111110.
6. Load 16'h9999, then assert rst_n low before the frame boundary -> no upd_done; after release, digit0 shows 1111110, not 1111011.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan driver.
//   seg_t           : 7-bit segment vector {A,B,C,D,E,F,G}, A is the MSB.
//   SEG_A..SEG_G    : bit index of each segment inside seg_t.
//   SEG_0..SEG_F    : hex glyph codes (active-high); SEG_BLANK lights nothing.
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam seg_t SA = 7'd1 << SEG_A;
  localparam seg_t SB = 7'd1 << SEG_B;
  localparam seg_t SC = 7'd1 << SEG_C;
  localparam seg_t SD = 7'd1 << SEG_D;
  localparam seg_t SE = 7'd1 << SEG_E;
  localparam seg_t SF = 7'd1 << SEG_F;
  localparam seg_t SG = 7'd1 << SEG_G;

  localparam seg_t SEG_0     = SA | SB | SC | SD | SE | SF;
  localparam seg_t SEG_1     = SB | SC;
  localparam seg_t SEG_2     = SA | SB | SD | SE | SG;
  localparam seg_t SEG_3     = SA | SB | SC | SD | SG;
  localparam seg_t SEG_4     = SB | SC | SF | SG;
  localparam seg_t SEG_5     = SA | SC | SD | SF | SG;
  localparam seg_t SEG_6     = SA | SC | SD | SE | SF | SG;
  localparam seg_t SEG_7     = SA | SB | SC;
  localparam seg_t SEG_8     = SA | SB | SC | SD | SE | SF | SG;
  localparam seg_t SEG_9     = SA | SB | SC | SD | SF | SG;
  localparam seg_t SEG_HA    = SA | SB | SC | SE | SF | SG;
  localparam seg_t SEG_HB    = SC | SD | SE | SF | SG;
  localparam seg_t SEG_HC    = SA | SD | SE | SF;
  localparam seg_t SEG_HD    = SB | SC | SD | SE | SG;
  localparam seg_t SEG_HE    = SA | SD | SE | SF | SG;
  localparam seg_t SEG_HF    = SA | SE | SF | SG;
  localparam seg_t SEG_BLANK = '0;

endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: combinational 4-bit nibble to seven-segment glyph (0-F).
//   nib : input nibble
//   seg : {A,B,C,D,E,F,G}, active-high
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_HA;
      4'hB: seg = SEG_HB;
      4'hC: seg = SEG_HC;
      4'hD: seg = SEG_HD;
      4'hE: seg = SEG_HE;
      4'hF: seg = SEG_HF;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: multiplexed NUM_DIGITS-digit hex seven-segment driver.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : one-cycle strobe capturing value/dp_in into the pending buffer
//   value      : nibble k (bits 4k+3:4k) is digit k
//   dp_in      : decimal point per digit
//   seg, dp    : segments {A..G} and dp of the enabled digit (registered)
//   an         : one-hot digit enable (registered)
//   upd_done   : one-cycle pulse on the first cycle a newly loaded value is shown
// Build option: define SSD_LZB_EN for leading-zero blanking of digits 1..N-1.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_done
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend_vld;
  logic                    commit_q;

  logic                    slot_end, frame_end, commit;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              dec_seg, seg_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign commit    = frame_end && pend_vld;

`ifdef SSD_LZB_EN
  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_val[4*k +: 4] == 4'h0);
      blank[k]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_nxt    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = disp_val[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = blank[k];
        an_nxt[k] = 1'b1;
      end
    end
  end

  ssd_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  assign seg_nxt = cur_blank ? SEG_BLANK : dec_seg;

  // commit_q delays the pulse one cycle so upd_done lines up with the
  // output registers first showing the freshly committed display value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
      commit_q <= 1'b0;
      upd_done <= 1'b0;
      seg      <= '0;
      dp       <= 1'b0;
      an       <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (commit) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end

      // A load on the commit edge refills pending and keeps the flag set.
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end

      commit_q <= commit;
      upd_done <= commit_q;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= cur_dp;
    end
  end

endmodule
